// File: rtl/ctrl_sequencer_pkg.sv
// Shared types for the control sequencer: state encoding, opcode/ALU constants, control word.
// Purely declarative; no latency.
// No flow control of its own.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      EXEC2  = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   localparam logic [3:0] OP_SYS  = 4'd0;
   localparam logic [3:0] OP_CALL = 4'd10;
   localparam logic [3:0] OP_RET  = 4'd11;

   localparam logic [2:0] SUB_HALT = 3'b000;
   localparam logic [2:0] SUB_NOP  = 3'b001;
   localparam logic [2:0] SUB_POP  = 3'b010;
   localparam logic [2:0] SUB_PUSH = 3'b011;
   localparam logic [2:0] SUB_ADDS = 3'b100;

   localparam logic [2:0] FN_ZERO = 3'd0;
   localparam logic [2:0] FN_DEC  = 3'd1;
   localparam logic [2:0] FN_ADD  = 3'd2;
   localparam logic [2:0] FN_NEG  = 3'd3;
   localparam logic [2:0] FN_OR   = 3'd4;
   localparam logic [2:0] FN_NOT  = 3'd5;
   localparam logic [2:0] FN_PASS = 3'd6;
   localparam logic [2:0] FN_INC  = 3'd7;

   typedef struct packed {
      logic       tlab;
      logic       tpcX;
      logic       tpc;
      logic       tRDM;
      logic       tregY;
      logic       treg;
      logic       RDM;
      logic       WRR;
      logic       ldsp;
      logic       spSel;
      logic       inc;
      logic       retCh;
      logic [2:0] fn;
      logic       pcEn;
   } ctrl_word_t;

   localparam ctrl_word_t CTRL_DEFAULT = '{
      tlab: 1'b0, tpcX: 1'b0, tpc: 1'b0, tRDM: 1'b0, tregY: 1'b0, treg: 1'b0,
      RDM: 1'b1, WRR: 1'b0, ldsp: 1'b0, spSel: 1'b0, inc: 1'b0, retCh: 1'b0,
      fn: FN_ZERO, pcEn: 1'b0};

   // Opcodes 12-15 and system subs 101-111 have no meaning.
   function automatic logic op_is_illegal(input logic [6:0] opc);
      return (opc[6:3] >= 4'd12) ||
             ((opc[6:3] == OP_SYS) && (opc[2:0] > SUB_ADDS));
   endfunction

   function automatic logic op_is_halt(input logic [6:0] opc);
      return (opc[6:3] == OP_SYS) && (opc[2:0] == SUB_HALT);
   endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Bundle between sequencer and datapath: opcode/run in, control strobes and status out.
// Wires only; no latency.
// No backpressure; the sequencer is paced by run.
interface ctrl_sequencer_if #(parameter int RETIRED_W = 16);
   logic                 run;
   logic [6:0]           IRController;
   logic                 tlab, tpcX, tpc, tRDM, tregY, treg;
   logic                 RDM, WRR, ldsp, spSel, inc, retCh;
   logic [2:0]           fn;
   logic                 pcEn;
   logic                 halted;
   logic                 illegal;
   logic [RETIRED_W-1:0] retired;
   logic [2:0]           state_dbg;

   modport master (
      input  run, IRController,
      output tlab, tpcX, tpc, tRDM, tregY, treg, RDM, WRR, ldsp, spSel, inc, retCh,
             fn, pcEn, halted, illegal, retired, state_dbg
   );

   modport slave (
      output run, IRController,
      input  tlab, tpcX, tpc, tRDM, tregY, treg, RDM, WRR, ldsp, spSel, inc, retCh,
             fn, pcEn, halted, illegal, retired, state_dbg
   );
endinterface

// File: rtl/ctrl_sequencer_microword.sv
// Maps (state, latched opcode) to the datapath control word.
// Combinational, zero latency.
// No flow control; outputs are Moore in state/op_q.
module ctrl_microword
   import cpu_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [6:0] op_q,
   output ctrl_word_t cw
);

   logic [3:0] op;
   logic [2:0] sub;

   assign op  = op_q[6:3];
   assign sub = op_q[2:0];

   // Start from the idle word; only EXEC/EXEC2/WB of legal ops raise strobes, so fn is ZERO elsewhere.
   always_comb begin
      cw = CTRL_DEFAULT;
      unique case (state)
         EXEC: begin
            if (op == OP_SYS) begin
               case (sub)
                  SUB_POP:  begin cw.tRDM = 1'b1; cw.fn = FN_PASS; end
                  SUB_PUSH: begin cw.spSel = 1'b1; cw.treg = 1'b1; cw.RDM = 1'b0; end
                  SUB_ADDS: begin cw.tRDM = 1'b1; cw.tregY = 1'b1; cw.fn = FN_ADD; end
                  default:  ;
               endcase
            end else if (op <= 4'd9) begin
               cw.tlab = 1'b1; cw.fn = FN_PASS;
            end else if (op == OP_CALL) begin
               cw.tpc = 1'b1; cw.spSel = 1'b1; cw.RDM = 1'b0;
            end else if (op == OP_RET) begin
               cw.tRDM = 1'b1; cw.fn = FN_PASS; cw.retCh = 1'b1;
            end
         end
         EXEC2: begin
            if (op == OP_CALL) begin
               cw.ldsp = 1'b1; cw.tlab = 1'b1; cw.fn = FN_PASS;
            end
         end
         WB: begin
            cw.pcEn = 1'b1;
            if (op == OP_SYS) begin
               case (sub)
                  SUB_POP:  begin cw.fn = FN_PASS; cw.WRR = 1'b1; cw.ldsp = 1'b1; cw.inc = 1'b1; end
                  SUB_PUSH: cw.ldsp = 1'b1;
                  SUB_ADDS: begin cw.fn = FN_ADD; cw.WRR = 1'b1; end
                  default:  ;
               endcase
            end else if (op <= 4'd9) begin
               cw.fn = FN_PASS;
            end else if (op == OP_CALL) begin
               cw.tlab = 1'b1; cw.fn = FN_PASS;
            end else if (op == OP_RET) begin
               cw.fn = FN_PASS; cw.retCh = 1'b1; cw.ldsp = 1'b1; cw.inc = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// Instruction sequencer: FETCH/DECODE/EXEC(/EXEC2)/WB with sticky halt/illegal and retire count.
// 4 cycles per instruction, 5 for CALL; strobes are Moore outputs of the current state.
// run=0 stalls in FETCH; HALT is absorbing until rst.
module ctrl_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int RETIRED_W = 16
)(
   input logic                 clk,
   input logic                 rst,
   ctrl_sequencer_if.master    bus
);

   state_t                state_q, state_nxt;
   logic [6:0]            op_q;
   logic                  halted_q, illegal_q;
   logic [RETIRED_W-1:0]  retired_q;
   ctrl_word_t            cw_raw, cw;

   ctrl_microword u_microword (
      .state (state_q),
      .op_q  (op_q),
      .cw    (cw_raw)
   );

   // Reset overrides strobes immediately so an interrupted write never lands.
   always_comb begin
      cw = rst ? CTRL_DEFAULT : cw_raw;
   end

   // Next-state: only EXEC branches on the opcode latched during DECODE.
   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         FETCH:  if (bus.run) state_nxt = DECODE;
         DECODE: state_nxt = EXEC;
         EXEC: begin
            if (op_is_halt(op_q) || op_is_illegal(op_q)) state_nxt = HALT;
            else if (op_q[6:3] == OP_CALL)               state_nxt = EXEC2;
            else                                          state_nxt = WB;
         end
         EXEC2:  state_nxt = WB;
         WB:     state_nxt = FETCH;
         HALT:   state_nxt = HALT;
         default: state_nxt = FETCH;
      endcase
   end

   // State, opcode latch, sticky flags and retire counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FETCH;
         op_q      <= '0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q <= state_nxt;
         if (state_q == DECODE) op_q <= bus.IRController;
         if (state_q == EXEC && state_nxt == HALT) begin
            halted_q <= 1'b1;
            if (op_is_illegal(op_q)) illegal_q <= 1'b1;
         end
         if (cw.pcEn) retired_q <= retired_q + 1'b1;
      end
   end

   assign bus.tlab      = cw.tlab;
   assign bus.tpcX      = cw.tpcX;
   assign bus.tpc       = cw.tpc;
   assign bus.tRDM      = cw.tRDM;
   assign bus.tregY     = cw.tregY;
   assign bus.treg      = cw.treg;
   assign bus.RDM       = cw.RDM;
   assign bus.WRR       = cw.WRR;
   assign bus.ldsp      = cw.ldsp;
   assign bus.spSel     = cw.spSel;
   assign bus.inc       = cw.inc;
   assign bus.retCh     = cw.retCh;
   assign bus.fn        = cw.fn;
   assign bus.pcEn      = cw.pcEn;
   assign bus.halted    = halted_q;
   assign bus.illegal   = illegal_q;
   assign bus.retired   = retired_q;
   assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for the control sequencer with hand-derived expectations.
// Checks land 2 time units after each rising edge.
// Inputs run/IRController/rst are driven at the same points.
module tb_ctrl_sequencer;

   localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                          S_EXEC2 = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   pc_pulses;

   ctrl_sequencer_if #(.RETIRED_W(16)) bus ();

   ctrl_sequencer #(.RETIRED_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Concatenation of every strobe, for checking "nothing asserted" in one go.
   function automatic logic [15:0] strobes();
      return {bus.tlab, bus.tpcX, bus.tpc, bus.tRDM, bus.tregY, bus.treg, bus.RDM,
              bus.WRR, bus.ldsp, bus.spSel, bus.inc, bus.retCh, bus.fn, bus.pcEn};
   endfunction

   localparam logic [15:0] IDLE = 16'b0000001_00000_000_0;

   initial begin
      bus.run = 1'b0;
      bus.IRController = 7'b0000000;
      tick(); tick();
      chk("rst_state",   bus.state_dbg, S_FETCH);
      chk("rst_halted",  bus.halted, 1'b0);
      chk("rst_illegal", bus.illegal, 1'b0);
      chk("rst_retired", bus.retired, 16'd0);
      chk("rst_strobes", strobes(), IDLE);
      rst = 1'b0;

      // NOP
      bus.run = 1'b1; bus.IRController = 7'b0000001;
      chk("nop_fetch_pcEn", bus.pcEn, 1'b0);
      tick(); chk("nop_decode", bus.state_dbg, S_DECODE); chk("nop_dec_RDM", bus.RDM, 1'b1);
      tick(); chk("nop_exec", bus.state_dbg, S_EXEC);     chk("nop_exec_pcEn", bus.pcEn, 1'b0);
      tick(); chk("nop_wb", bus.state_dbg, S_WB);         chk("nop_wb_pcEn", bus.pcEn, 1'b1);
              chk("nop_wb_RDM", bus.RDM, 1'b1);
      tick(); chk("nop_retired", bus.retired, 16'd1);     chk("nop_back_fetch", bus.state_dbg, S_FETCH);

      // Two back-to-back POPs
      bus.IRController = 7'b0000010;
      for (int k = 0; k < 2; k++) begin
         tick(); chk("pop_dec_fn", bus.fn, 3'd0);
         tick(); chk("pop_exec_tRDM", bus.tRDM, 1'b1); chk("pop_exec_fn", bus.fn, 3'd6);
                 chk("pop_exec_spSel", bus.spSel, 1'b0);
         tick(); chk("pop_wb_fn", bus.fn, 3'd6); chk("pop_wb_WRR", bus.WRR, 1'b1);
                 chk("pop_wb_ldsp", bus.ldsp, 1'b1); chk("pop_wb_inc", bus.inc, 1'b1);
                 chk("pop_wb_pcEn", bus.pcEn, 1'b1);
         tick(); chk("pop_fetch_fn", bus.fn, 3'd0);
      end
      chk("pop_retired", bus.retired, 16'd3);

      // CALL (5 cycles)
      bus.IRController = 7'b1010101;
      tick();
      tick(); chk("call_exec_RDM", bus.RDM, 1'b0); chk("call_exec_tpc", bus.tpc, 1'b1);
              chk("call_exec_spSel", bus.spSel, 1'b1); chk("call_exec_inc", bus.inc, 1'b0);
              chk("call_exec_pcEn", bus.pcEn, 1'b0);
      tick(); chk("call_exec2", bus.state_dbg, S_EXEC2); chk("call_e2_ldsp", bus.ldsp, 1'b1);
              chk("call_e2_tlab", bus.tlab, 1'b1); chk("call_e2_RDM", bus.RDM, 1'b1);
              chk("call_e2_pcEn", bus.pcEn, 1'b0);
      tick(); chk("call_wb_pcEn", bus.pcEn, 1'b1); chk("call_wb_tlab", bus.tlab, 1'b1);
      tick(); chk("call_retired", bus.retired, 16'd4);

      // ADDS
      bus.IRController = 7'b0000100;
      tick();
      tick(); chk("adds_exec_fn", bus.fn, 3'd2); chk("adds_exec_tregY", bus.tregY, 1'b1);
              chk("adds_exec_tRDM", bus.tRDM, 1'b1);
      tick(); chk("adds_wb_WRR", bus.WRR, 1'b1); chk("adds_wb_fn", bus.fn, 3'd2);
      tick();

      // Branch, op 3
      bus.IRController = 7'b0011000;
      tick();
      tick(); chk("br_exec_tlab", bus.tlab, 1'b1); chk("br_exec_fn", bus.fn, 3'd6);
      tick(); chk("br_wb_pcEn", bus.pcEn, 1'b1); chk("br_wb_tlab", bus.tlab, 1'b0);
      tick();

      // RET
      bus.IRController = 7'b1011000;
      tick();
      tick(); chk("ret_exec_retCh", bus.retCh, 1'b1); chk("ret_exec_tRDM", bus.tRDM, 1'b1);
      tick(); chk("ret_wb_ldsp", bus.ldsp, 1'b1); chk("ret_wb_inc", bus.inc, 1'b1);
              chk("ret_wb_retCh", bus.retCh, 1'b1);
      tick(); chk("ret_retired", bus.retired, 16'd7);

      // PUSH interrupted by reset in EXEC
      bus.IRController = 7'b0000011;
      tick();
      tick(); chk("push_exec_RDM", bus.RDM, 1'b0); chk("push_exec_treg", bus.treg, 1'b1);
              chk("push_exec_spSel", bus.spSel, 1'b1);
      rst = 1'b1; #1;
      chk("push_rst_RDM", bus.RDM, 1'b1); chk("push_rst_treg", bus.treg, 1'b0);
      chk("push_rst_state", bus.state_dbg, S_EXEC);
      tick(); chk("push_rst_fetch", bus.state_dbg, S_FETCH); chk("push_rst_retired", bus.retired, 16'd0);
      rst = 1'b0;

      // Full PUSH
      tick();
      tick();
      tick(); chk("push_wb_ldsp", bus.ldsp, 1'b1); chk("push_wb_inc", bus.inc, 1'b0);
              chk("push_wb_pcEn", bus.pcEn, 1'b1); chk("push_wb_RDM", bus.RDM, 1'b1);
      tick(); chk("push_retired", bus.retired, 16'd1);

      // Stall in FETCH, with retired preloaded to max
      bus.run = 1'b0;
      force dut.retired_q = 16'hFFFF;
      tick();
      release dut.retired_q;
      for (int k = 0; k < 3; k++) begin
         chk("stall_state", bus.state_dbg, S_FETCH);
         chk("stall_strobes", strobes(), IDLE);
         tick();
      end
      chk("preload_retired", bus.retired, 16'hFFFF);
      bus.run = 1'b1; bus.IRController = 7'b0000001;
      tick(); tick(); tick(); tick();
      chk("wrap_retired", bus.retired, 16'h0000);

      // HALT opcode
      bus.IRController = 7'b0000000;
      tick(); tick(); chk("halt_exec_pcEn", bus.pcEn, 1'b0);
      tick(); chk("halt_state", bus.state_dbg, S_HALT); chk("halt_halted", bus.halted, 1'b1);
              chk("halt_illegal", bus.illegal, 1'b0); chk("halt_retired", bus.retired, 16'd0);
      rst = 1'b1; tick(); rst = 1'b0;

      // Illegal opcode
      bus.IRController = 7'b1100000;
      tick(); tick(); chk("ill_exec_strobes", strobes(), IDLE);
      tick(); chk("ill_state", bus.state_dbg, S_HALT); chk("ill_illegal", bus.illegal, 1'b1);
              chk("ill_halted", bus.halted, 1'b1);
      pc_pulses = 0;
      for (int k = 0; k < 10; k++) begin
         if (bus.pcEn) pc_pulses++;
         tick();
      end
      chk("ill_no_pcEn", pc_pulses, 0);
      chk("ill_still_halt", bus.state_dbg, S_HALT);
      chk("ill_retired", bus.retired, 16'd0);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("ill_rst_state", bus.state_dbg, S_FETCH);
      chk("ill_rst_illegal", bus.illegal, 1'b0);
      chk("ill_rst_halted", bus.halted, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
